// File: rtl/nios2_debug_pkg.sv
// Shared types and helpers for the Nios II debug command synchroniser.
// Holds the FSM state type, synchroniser depth limits and the instruction decoder.
package nios2_debug_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cmd_state_e;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  // Decoder is sized for the widest supported IR; callers keep the low 2**IR_W bits.
  localparam int MAX_IR_W = 8;
  localparam int MAX_N_IR = 2 ** MAX_IR_W;

  function automatic logic [MAX_N_IR-1:0] onehot_dec(input logic [MAX_IR_W-1:0] idx);
    logic [MAX_N_IR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/nios2_debug_cmd_sync_if.sv
// Command port between the debug synchroniser (master) and the CPU debug logic (slave).
// Command fields are held while cmd_valid; action pulses last one cycle.
interface nios2_debug_cmd_sync_if #(
  parameter int IR_W = 2,
  parameter int SR_W = 38
);
  localparam int N_IR = 2 ** IR_W;

  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [N_IR-1:0] take_action;
  logic [N_IR-1:0] take_no_action;

  modport master (
    output jdo, cmd_ir, cmd_valid, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  jdo, cmd_ir, cmd_valid, take_action, take_no_action,
    output cmd_ready
  );

endinterface

// File: rtl/nios2_debug_strobe_sync.sv
// Level strobe synchroniser with registered rising-edge pulse.
// Latency: pulse high during cycle E0+SYNC_STAGES after the strobe is first sampled; no backpressure.
module nios2_debug_strobe_sync
  import nios2_debug_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);
  localparam int N = (SYNC_STAGES < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES :
                     (SYNC_STAGES > SYNC_MAX_STAGES) ? SYNC_MAX_STAGES : SYNC_STAGES;

  logic [N-1:0] chain;
  logic         last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain  <= '0;
      last_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      chain  <= {chain[N-2:0], strobe};
      last_q <= chain[N-1];
      pulse  <= chain[N-1] & ~last_q;
    end
  end

endmodule

// File: rtl/nios2_debug_cmd_sync.sv
// System-clock half of the JTAG debug bridge: captures scan words into a held command.
// Latency: cmd_valid from edge E0+SYNC_STAGES+1; held until cmd_ready or timeout, later DR updates dropped.
module nios2_debug_cmd_sync
  import nios2_debug_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  nios2_debug_cmd_sync_if.master cmd,
  output logic                   ir_update,
  output logic                   overrun,
  output logic                   timed_out,
  input  logic                   flag_clr
);
  localparam int          N_IR    = 2 ** IR_W;
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  cmd_state_e          state;
  logic [15:0]         to_cnt;
  logic                udr_rise;
  logic                uir_rise;
  logic [MAX_N_IR-1:0] dec_full;
  logic [N_IR-1:0]     ir_dec;

  nios2_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_udr),
    .pulse  (udr_rise)
  );

  nios2_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_uir),
    .pulse  (uir_rise)
  );

  assign ir_update = uir_rise;
  assign dec_full  = onehot_dec(MAX_IR_W'(ir_in));
  assign ir_dec    = dec_full[N_IR-1:0];

  generate
    if (N_IR < MAX_N_IR) begin : g_dec_hi
      logic unused_dec_hi;
      assign unused_dec_hi = |dec_full[MAX_N_IR-1:N_IR];
    end
  endgenerate

  // ir_in/sr are guaranteed stable for several cycles after the udr rise, so
  // decoding them directly equals decoding the captured jdo/cmd_ir.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      to_cnt             <= '0;
      cmd.jdo            <= '0;
      cmd.cmd_ir         <= '0;
      cmd.cmd_valid      <= 1'b0;
      cmd.take_action    <= '0;
      cmd.take_no_action <= '0;
      overrun            <= 1'b0;
      timed_out          <= 1'b0;
    end else begin
      cmd.take_action    <= '0;
      cmd.take_no_action <= '0;
      if (flag_clr) begin
        overrun   <= 1'b0;
        timed_out <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (udr_rise) begin
            state         <= HOLD;
            cmd.jdo       <= sr;
            cmd.cmd_ir    <= ir_in;
            cmd.cmd_valid <= 1'b1;
            to_cnt        <= TO_LOAD;
            if (sr[ACT_BIT]) cmd.take_action    <= ir_dec;
            else             cmd.take_no_action <= ir_dec;
          end
        end
        HOLD: begin
          // Sets are written after the clear above so a same-cycle set wins.
          if (udr_rise) overrun <= 1'b1;
          if (cmd.cmd_ready) begin
            state         <= IDLE;
            cmd.cmd_valid <= 1'b0;
          end else if (TO_EN && to_cnt == 16'd0) begin
            state         <= IDLE;
            cmd.cmd_valid <= 1'b0;
            timed_out     <= 1'b1;
          end else if (to_cnt != 16'd0) begin
            to_cnt <= to_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
